// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// AXI3 responder backed by an internal array of 2^ADDR_W 32-bit words.
// The read and write engines are independent. Each engine handles one
// transaction at a time and supports INCR and FIXED bursts (burst codes
// 10/11 are treated as INCR).
//
// Parameters:
//   ADDR_W   - word address width; word index = addr[ADDR_W+1:2]
//   RD_DELAY - idle cycles between the AR handshake and the first R beat
//   B_DELAY  - idle cycles between the last W handshake and bvalid
//
// Ports:
//   clk, resetn             - clock, asynchronous active-low reset
//   ar*  / r*               - read address / read data channels
//   aw*  / w* / b*          - write address / write data / write response
//   *lock, *cache, *prot, wid are accepted but ignored
//
// Responses:
//   rresp / bresp return SLVERR (2'b10) when the beat size is above 32 bits.
//   bresp also returns SLVERR when wlast does not arrive on beat awlen.
//   Read data is still returned, and write data is still stored, on error.

module axi_sram_slave #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RD_DELAY = 2,
    parameter int unsigned B_DELAY  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t          r_state, r_state_n;
    logic [3:0]        rd_id;
    logic [ADDR_W-1:0] rd_idx, rd_idx_next;
    logic [7:0]        rd_len, rd_beat;
    logic              rd_fixed, rd_err;
    logic [3:0]        rd_cnt;
    logic [31:0]       rdata_q;
    logic              arready_q;

    w_state_t          w_state, w_state_n;
    logic [3:0]        wr_id;
    logic [ADDR_W-1:0] wr_idx;
    logic [7:0]        wr_len, wr_beat;
    logic              wr_fixed, wr_size_err, wr_err;
    logic [3:0]        wr_cnt;
    logic              bvalid_q, awready_q;

    logic              ar_hs, r_hs, rd_last, aw_hs, w_hs, b_hs;
    logic [ADDR_W-1:0] ar_idx, aw_idx;

    logic unused_ok;
    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                         araddr[31:ADDR_W+2], araddr[1:0],
                         awaddr[31:ADDR_W+2], awaddr[1:0]};

    assign ar_idx      = araddr[ADDR_W+1:2];
    assign aw_idx      = awaddr[ADDR_W+1:2];
    assign ar_hs       = arvalid && arready;
    assign r_hs        = rvalid && rready;
    assign rd_last     = (rd_beat == rd_len);
    assign rd_idx_next = rd_fixed ? rd_idx : rd_idx + ADDR_W'(1);
    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign b_hs        = bvalid && bready;

    assign arready = arready_q;
    assign rvalid  = (r_state == R_DATA);
    assign rid     = rd_id;
    assign rdata   = rdata_q;
    assign rlast   = rvalid && rd_last;
    assign rresp   = (rvalid && rd_err) ? 2'b10 : 2'b00;
    assign awready = awready_q;
    assign wready  = (w_state == W_DATA);
    assign bvalid  = bvalid_q;
    assign bid     = wr_id;
    assign bresp   = (bvalid_q && wr_err) ? 2'b10 : 2'b00;

    // ---------------- read engine ----------------
    always_comb begin
        r_state_n = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_n = (RD_DELAY == 0) ? R_DATA : R_WAIT;
            R_WAIT:  if (rd_cnt == '0) r_state_n = R_DATA;
            R_DATA:  if (r_hs && rd_last) r_state_n = R_IDLE;
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= R_IDLE;
        else         r_state <= r_state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arready_q <= 1'b0;
            rd_id     <= '0;
            rd_idx    <= '0;
            rd_len    <= '0;
            rd_beat   <= '0;
            rd_fixed  <= 1'b0;
            rd_err    <= 1'b0;
            rd_cnt    <= '0;
            rdata_q   <= '0;
        end else begin
            // arready is registered, so it follows the state the engine enters
            arready_q <= (r_state_n == R_IDLE);
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    rd_id    <= arid;
                    rd_idx   <= ar_idx;
                    rd_len   <= arlen;
                    rd_beat  <= '0;
                    rd_fixed <= (arburst == 2'b00);
                    rd_err   <= (arsize > 3'b010);
                    rd_cnt   <= 4'(RD_DELAY);
                    if (RD_DELAY == 0) rdata_q <= mem[ar_idx];
                end
                R_WAIT: begin
                    if (rd_cnt == '0) rdata_q <= mem[rd_idx];
                    else              rd_cnt  <= rd_cnt - 4'd1;
                end
                R_DATA: if (r_hs && !rd_last) begin
                    // prefetch the next beat so rvalid stays high back-to-back
                    rd_idx  <= rd_idx_next;
                    rd_beat <= rd_beat + 8'd1;
                    rdata_q <= mem[rd_idx_next];
                end
                default: ;
            endcase
        end
    end

    // ---------------- write engine ----------------
    always_comb begin
        w_state_n = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_n = W_DATA;
            W_DATA:  if (w_hs && wlast) w_state_n = W_RESP;
            W_RESP:  if (b_hs) w_state_n = W_IDLE;
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) w_state <= W_IDLE;
        else         w_state <= w_state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            awready_q   <= 1'b0;
            wr_id       <= '0;
            wr_idx      <= '0;
            wr_len      <= '0;
            wr_beat     <= '0;
            wr_fixed    <= 1'b0;
            wr_size_err <= 1'b0;
            wr_err      <= 1'b0;
            wr_cnt      <= '0;
            bvalid_q    <= 1'b0;
        end else begin
            awready_q <= (w_state_n == W_IDLE);
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    wr_id       <= awid;
                    wr_idx      <= aw_idx;
                    wr_len      <= awlen;
                    wr_beat     <= '0;
                    wr_fixed    <= (awburst == 2'b00);
                    wr_size_err <= (awsize > 3'b010);
                    wr_err      <= 1'b0;
                end
                W_DATA: if (w_hs) begin
                    wr_idx  <= wr_fixed ? wr_idx : wr_idx + ADDR_W'(1);
                    wr_beat <= wr_beat + 8'd1;
                    if (wlast) begin
                        wr_err <= (wr_beat != wr_len) || wr_size_err;
                        wr_cnt <= 4'(B_DELAY);
                    end
                end
                W_RESP: begin
                    // count down the response delay, then hold bvalid until bready
                    if (!bvalid_q) begin
                        if (wr_cnt == '0) bvalid_q <= 1'b1;
                        else              wr_cnt   <= wr_cnt - 4'd1;
                    end else if (bready) begin
                        bvalid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; wready is low during reset so no write can occur.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Testbench for axi_sram_slave: a word-array reference model, stimulus tasks
// that push expected R beats / B responses into queues, and a negedge
// monitor that compares DUT outputs against the queue heads.

module tb_axi_sram_slave;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned RD_DELAY = 2;
    localparam int unsigned B_DELAY  = 1;

    logic        clk, resetn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_sram_slave #(.ADDR_W(ADDR_W), .RD_DELAY(RD_DELAY), .B_DELAY(B_DELAY)) dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(2'b00), .arcache(4'h0), .arprot(3'b000),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(2'b00), .awcache(4'h0), .awprot(3'b000),
        .awvalid(awvalid), .awready(awready),
        .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        bit          last;
        logic [1:0]  resp;
        int          due;
        bit          first;
    } rbeat_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
        int         due;
    } bexp_t;

    rbeat_t rq[$];
    bexp_t  bq[$];
    bit r_lat_done = 0, b_lat_done = 0;
    bit chk_arready = 0, chk_awready = 0;

    // reference model: one 32-bit word per index, plus the open write burst
    logic [31:0] mem_m [1024];
    logic [31:0] wdat [16];
    logic [3:0]  wst  [16];
    logic [9:0]  w_idx;
    logic [7:0]  w_len;
    bit          w_fixed, w_serr, w_gaps;
    logic [3:0]  w_id;

    int rr_mode = 0;   // 0 always ready, 1 random, 2 five-cycle stall per beat, 3 never
    bit bb_mode = 0;   // 0 always ready, 1 random
    int stall   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(string name, string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %s (cycle %0d)", name, what, cyc);
    endfunction

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0: rready = 1'b1;
            1: rready = ($urandom_range(0, 3) != 0);
            2: begin
                if (rready) begin
                    rready = 1'b0;
                    stall  = 0;
                end else if (rvalid) begin
                    stall++;
                    if (stall >= 5) rready = 1'b1;
                end
            end
            default: rready = 1'b0;
        endcase
        bready = bb_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (resetn) begin
            if (chk_arready) begin
                check("arready_after_rlast", {31'd0, arready}, 32'd1);
                chk_arready = 0;
            end
            if (chk_awready) begin
                check("awready_after_b", {31'd0, awready}, 32'd1);
                chk_awready = 0;
            end
            if (awready) check("wready_before_aw", {31'd0, wready}, 32'd0);
            if (rq.size() > 0) check("arready_while_busy", {31'd0, arready}, 32'd0);
            if (rvalid) begin
                if (rq.size() == 0) begin
                    fail_now("r_unexpected", "rvalid with no beat expected");
                end else begin
                    if (rq[0].first && !r_lat_done) begin
                        check("r_latency_cycle", cyc, rq[0].due);
                        r_lat_done = 1;
                    end
                    check("rid",   {28'd0, rid},   {28'd0, rq[0].id});
                    check("rdata", rdata,          rq[0].data);
                    check("rlast", {31'd0, rlast}, {31'd0, rq[0].last});
                    check("rresp", {30'd0, rresp}, {30'd0, rq[0].resp});
                    if (rready) begin
                        if (rq[0].last) chk_arready = 1;
                        void'(rq.pop_front());
                        r_lat_done = 0;
                    end
                end
            end
            if (bvalid) begin
                if (bq.size() == 0) begin
                    fail_now("b_unexpected", "bvalid with no response expected");
                end else begin
                    if (!b_lat_done) begin
                        check("b_latency_cycle", cyc, bq[0].due);
                        b_lat_done = 1;
                    end
                    check("bid",   {28'd0, bid},   {28'd0, bq[0].id});
                    check("bresp", {30'd0, bresp}, {30'd0, bq[0].resp});
                    if (bready) begin
                        chk_awready = 1;
                        void'(bq.pop_front());
                        b_lat_done = 0;
                    end
                end
            end
        end
    end

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
        bit ok = 0;
        int hs;
        logic [9:0] idx;
        rbeat_t e;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        hs = cyc + 1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (!ok) begin fail_now("ar_handshake", "timeout, expected arready"); return; end
        idx = addr[11:2];
        for (int b = 0; b <= int'(len); b++) begin
            e.id    = id;
            e.data  = mem_m[idx];
            e.last  = (b == int'(len));
            e.resp  = (size > 3'd2) ? 2'b10 : 2'b00;
            e.due   = hs + int'(RD_DELAY) + 1;
            e.first = (b == 0);
            rq.push_back(e);
            if (burst != 2'b00) idx = idx + 10'd1;
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
        bit ok = 0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        if (!ok) fail_now("aw_handshake", "timeout, expected awready");
        w_id = id; w_idx = addr[11:2]; w_len = len;
        w_fixed = (burst == 2'b00); w_serr = (size > 3'd2);
    endtask

    task automatic do_w(input int nbeats, input bit give_last);
        int hs = 0;
        bit ok;
        bexp_t e;
        for (int b = 0; b < nbeats; b++) begin
            if (w_gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            wvalid = 1'b1; wdata = wdat[b]; wstrb = wst[b];
            wlast = give_last && (b == nbeats - 1);
            ok = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (wready) begin ok = 1; break; end
            end
            if (!ok) begin
                fail_now("w_handshake", "timeout, expected wready");
                wvalid = 1'b0; wlast = 1'b0;
                return;
            end
            for (int k = 0; k < 4; k++)
                if (wst[b][k]) mem_m[w_idx][8*k +: 8] = wdat[b][8*k +: 8];
            hs = cyc + 1;
            @(posedge clk); #1;
            wvalid = 1'b0; wlast = 1'b0;
            if (!w_fixed) w_idx = w_idx + 10'd1;
        end
        if (give_last) begin
            e.id   = w_id;
            e.resp = ((nbeats - 1 != int'(w_len)) || w_serr) ? 2'b10 : 2'b00;
            e.due  = hs + int'(B_DELAY) + 1;
            bq.push_back(e);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rq.size() == 0 && bq.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            fail_now("idle_wait", $sformatf("%0d R / %0d B outstanding, expected 0", rq.size(), bq.size()));
            rq.delete(); bq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_words(input logic [31:0] d, input logic [3:0] s, input int n);
        for (int k = 0; k < n; k++) begin wdat[k] = d + 32'h11 * k; wst[k] = s; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  wl, rl;
        logic [1:0]  wb, rb;
        logic [2:0]  ws;
        logic [3:0]  wi;
        logic [31:0] wa, ra;
        int nb;

        resetn = 1'b0; w_gaps = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; rready = 1; bready = 1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rdata",   rdata,            32'd0);
        resetn = 1'b1;
        #1;
        check("rel_arready_pre", {31'd0, arready}, 32'd0);
        @(posedge clk); #1;
        check("rel_arready_post", {31'd0, arready}, 32'd1);
        check("rel_awready_post", {31'd0, awready}, 32'd1);

        // initialise every word through the DUT so all reads are defined
        for (int blk = 0; blk < 64; blk++) begin
            for (int k = 0; k < 16; k++) begin wdat[k] = $urandom; wst[k] = 4'hF; end
            do_aw(4'(blk), 32'(blk * 64), 8'd15, 2'b01, 3'd2);
            do_w(16, 1);
            wait_idle();
        end

        // single-beat write then read
        wdat[0] = 32'hDEADBEEF; wst[0] = 4'hF;
        do_aw(4'd2, 32'h10, 8'd0, 2'b01, 3'd2); do_w(1, 1); wait_idle();
        do_ar(4'd3, 32'h10, 8'd0, 2'b01, 3'd2); wait_idle();

        // four-beat INCR write / read-back
        fill_words(32'h11, 4'hF, 4);
        do_aw(4'd5, 32'h100, 8'd3, 2'b01, 3'd2); do_w(4, 1); wait_idle();
        do_ar(4'd6, 32'h100, 8'd3, 2'b01, 3'd2); wait_idle();

        // partial strobes over a zero word
        wdat[0] = 32'h0; wst[0] = 4'hF;
        do_aw(4'd1, 32'h200, 8'd0, 2'b01, 3'd2); do_w(1, 1); wait_idle();
        wdat[0] = 32'hAABBCCDD; wst[0] = 4'b0101;
        do_aw(4'd1, 32'h200, 8'd0, 2'b01, 3'd2); do_w(1, 1); wait_idle();
        do_ar(4'd9, 32'h200, 8'd0, 2'b01, 3'd2); wait_idle();

        // R stalled five cycles per beat
        rr_mode = 2;
        do_ar(4'd7, 32'h100, 8'd2, 2'b01, 3'd2); wait_idle();
        rr_mode = 0;

        // early wlast, oversize read
        fill_words(32'h5A5A0000, 4'hF, 4);
        do_aw(4'd9, 32'h300, 8'd3, 2'b01, 3'd2); do_w(2, 1); wait_idle();
        do_ar(4'd10, 32'h300, 8'd1, 2'b01, 3'd3); wait_idle();

        // FIXED burst: all beats land on one word
        for (int k = 0; k < 4; k++) begin wdat[k] = $urandom; wst[k] = 4'($urandom); end
        do_aw(4'd4, 32'h400, 8'd3, 2'b00, 3'd2); do_w(4, 1); wait_idle();
        do_ar(4'd4, 32'h400, 8'd2, 2'b00, 3'd2); wait_idle();

        // INCR wrap past the top word, upper address bits ignored
        fill_words(32'hC0DE0000, 4'hF, 3);
        do_aw(4'd8, 32'h0000_0FFC, 8'd2, 2'b01, 3'd2); do_w(3, 1); wait_idle();
        do_ar(4'd8, 32'hABCD_0FFC, 8'd2, 2'b11, 3'd2); wait_idle();

        // random concurrent traffic: writes in the lower half, reads in the upper half
        rr_mode = 1; bb_mode = 1; w_gaps = 1;
        for (int it = 0; it < 40; it++) begin
            wl = 8'($urandom_range(0, 7));
            wb = 2'($urandom_range(0, 3));
            ws = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'd2;
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, int'(wl) + 1)) : int'(wl) + 1;
            wa = {20'($urandom), 10'($urandom_range(0, 503)), 2'($urandom)};
            wi = 4'($urandom);
            rl = 8'($urandom_range(0, 7));
            rb = 2'($urandom_range(0, 3));
            ra = {20'($urandom), 10'($urandom_range(512, 1015)), 2'($urandom)};
            for (int k = 0; k < 16; k++) begin wdat[k] = $urandom; wst[k] = 4'($urandom); end
            fork
                begin do_aw(wi, wa, wl, wb, ws); do_w(nb, 1); end
                do_ar(wi + 4'd1, ra, rl, rb, 3'd2);
            join
            wait_idle();
            do_ar(wi + 4'd2, wa, wl, wb, 3'd2);
            wait_idle();
        end
        rr_mode = 0; bb_mode = 0; w_gaps = 0;

        // reset in the middle of a read burst and a write burst
        rr_mode = 3;
        fill_words(32'h77770000, 4'hF, 8);
        do_ar(4'd1, 32'h40, 8'd15, 2'b01, 3'd2);
        do_aw(4'd2, 32'h500, 8'd7, 2'b01, 3'd2);
        do_w(2, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        resetn = 1'b0;
        #1;
        check("midrst_rvalid",  {31'd0, rvalid},  32'd0);
        check("midrst_bvalid",  {31'd0, bvalid},  32'd0);
        check("midrst_wready",  {31'd0, wready},  32'd0);
        check("midrst_arready", {31'd0, arready}, 32'd0);
        check("midrst_awready", {31'd0, awready}, 32'd0);
        rq.delete(); bq.delete();
        r_lat_done = 0; b_lat_done = 0; chk_arready = 0; chk_awready = 0;
        rr_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("midrst_rel_arready_pre", {31'd0, arready}, 32'd0);
        check("midrst_rel_awready_pre", {31'd0, awready}, 32'd0);
        @(posedge clk); #1;
        check("midrst_rel_arready_post", {31'd0, arready}, 32'd1);
        check("midrst_rel_awready_post", {31'd0, awready}, 32'd1);

        // fresh traffic after reset
        fill_words(32'h0BAD0000, 4'hF, 2);
        do_aw(4'd3, 32'h504, 8'd1, 2'b01, 3'd2); do_w(2, 1); wait_idle();
        do_ar(4'd4, 32'h500, 8'd3, 2'b01, 3'd2); wait_idle();

        repeat (3) @(posedge clk);
        check("final_r_queue", 32'(rq.size()), 32'd0);
        check("final_b_queue", 32'(bq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI3 slave (responder) backed by an internal word-addressed memory array; the target end of the AXI channels driven by the CPU-side SRAM-to-AXI bridge. Used as a bench and simulation memory, and as a simple on-chip RAM. Independent read and write engines, one outstanding transaction each, with INCR/FIXED bursts and configurable response latency.

Parameters:
ADDR_W, 10, memory depth is 2^ADDR_W 32-bit words; word index = addr[ADDR_W+1:2], upper bits ignored.
RD_DELAY, 2, idle cycles between AR handshake and first R beat (0..15).
B_DELAY, 1, idle cycles between last W handshake and bvalid (0..15).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
arid  in  4  read ID
araddr  in  32  read byte address
arlen  in  8  beats-1
arsize  in  3  beat size
arburst  in  2  00 FIXED, 01 INCR, others treated as INCR
arlock/arcache/arprot  in  2/4/3  ignored
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  4  echoed arid
rdata  out  32  read data
rresp  out  2  response
rlast  out  1  last beat
rvalid  out  1  R valid
rready  in  1  R ready
awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  as AR
awlock/awcache/awprot  in  2/4/3  ignored
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  4  ignored (AXI3, in-order)
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  4  echoed awid
bresp  out  2  response
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset (async, resetn=0): all outputs 0, both FSMs idle, counters cleared; memory array not reset. arready/awready are registered and rise on the first clk edge after resetn deasserts.
- Read FSM R_IDLE -> R_WAIT -> R_DATA:
  - R_IDLE: arready=1. On arvalid&&arready, latch id, addr, len, burst, size, clear beat count, load delay counter with RD_DELAY. arready drops next cycle.
  - R_WAIT: decrement the counter. When it is 0 (same cycle as the handshake if RD_DELAY=0), register rdata=mem[word], enter R_DATA. First rvalid therefore appears RD_DELAY+1 cycles after the AR handshake.
  - R_DATA: rvalid=1. rdata, rid, rresp and rlast are held stable while rready=0. rlast=(beat==len).
  - On rvalid&&rready, not last: advance the address (+4 INCR, unchanged FIXED, word index wraps modulo 2^ADDR_W), beat+1, register the next rdata, rvalid stays 1 (back-to-back beats).
  - On rvalid&&rready, last: rvalid=0 and arready=1 next cycle.
  - rresp=10 (SLVERR) for every beat when arsize>3'b010, otherwise 00. Data is still returned.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1, wready=0. On the AW handshake, latch the fields and go to W_DATA.
  - W_DATA: wready=1. On each wvalid&&wready, write the bytes of wdata selected by wstrb to mem[word] at the clk edge, then advance the address as for reads.
  - Burst ends on the beat with wlast=1. If that beat index != awlen, or awsize>2, set an error flag so bresp=10.
  - The W handshake is never accepted before the AW handshake.
  - W_RESP: wait B_DELAY cycles, then bvalid=1 with bid=latched awid and bresp=00 (or 10 if the error flag is set). bvalid and bid are held until bready. After the B handshake, return to W_IDLE with awready=1 next cycle.
- Simultaneous read sample and write to the same word on the same edge: the read captures the old (pre-write) data. The write is visible to any read sampled on a later edge.
- Read and write engines are fully concurrent; no ordering between channels.

Test Plan:
- RD_DELAY=2: AR addr 0x10, len 0, id 3, after mem[4] is written with 0xDEADBEEF -> rvalid 3 cycles after the handshake, rdata=0xDEADBEEF, rid=3, rlast=1, rresp=00; arready 1 again the following cycle.
- AW addr 0x100, len 3, INCR, id 5, W beats 0x11..0x44 with strb F -> bvalid 2 cycles after the wlast handshake, bid=5, bresp=00. A 4-beat read-back returns 0x11,0x22,0x33,0x44 with rlast only on beat 4.
- Write 0xAABBCCDD strb 0101 over a word holding 0 -> read back 0x00BB00DD.
- Read burst len 2 with rready low 5 cycles per beat -> rdata, rlast and rid stable while stalled; exactly 3 beats delivered.
- Write with wlast on beat 1 of a len 3 burst -> bresp=10. arsize=3 read -> rresp=10 on all beats.
- Assert resetn low mid-read-burst and mid-write -> rvalid, bvalid, wready, arready and awready all 0 immediately. After release, arready and awready are 1 one edge later and a fresh transaction completes normally.
